// File: rtl/hawk_reg_slave.sv
// Hawk register slave: reg_intf window holding the HACD core control registers,
// interrupt status/enable and the compression counter.
// Optional feature: define HAWK_REG_SCRATCH_EN to map a SCRATCH register at offset 0x1C.

package hawk_reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_intf_req_a32_d32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_intf_resp_d32;

    typedef struct packed {
        logic [31:0] ctrl;
        logic [31:0] low_wm;
        logic [31:0] cmpct_th;
    } hawk_regs_intf;

endpackage

module hawk_reg_slave
    import hawk_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  reg_intf_req_a32_d32 reg_req_i,
    output reg_intf_resp_d32    reg_resp_o,
    output hawk_regs_intf       hawk_regs_o,
    input  logic [15:0]         freepage_count_i,
    input  logic                cmpresn_done_i,
    input  logic                decomp_done_i,
    input  logic                illegal_access_i,
    output logic                irq_o
);

    localparam int unsigned NUM_IRQ = 4;

    localparam logic [31:0] OFS_CTRL     = 32'h00;
    localparam logic [31:0] OFS_LOW_WM   = 32'h04;
    localparam logic [31:0] OFS_CMPCT_TH = 32'h08;
    localparam logic [31:0] OFS_STATUS   = 32'h0C;
    localparam logic [31:0] OFS_INT_STS  = 32'h10;
    localparam logic [31:0] OFS_INT_EN   = 32'h14;
    localparam logic [31:0] OFS_CMP_CNT  = 32'h18;
`ifdef HAWK_REG_SCRATCH_EN
    localparam logic [31:0] OFS_SCRATCH  = 32'h1C;
`endif

    typedef enum logic {IDLE, RESP} state_e;

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 error_q, error_d;
    logic [31:0]          ctrl_q, ctrl_d;
    logic [31:0]          low_wm_q, low_wm_d;
    logic [31:0]          cmpct_th_q, cmpct_th_d;
    logic [NUM_IRQ-1:0]   int_sts_q, int_sts_d;
    logic [NUM_IRQ-1:0]   int_en_q, int_en_d;
    logic [31:0]          cmp_cnt_q, cmp_cnt_d;
    logic                 below_q, below_d;
    logic                 irq_q, irq_d;
`ifdef HAWK_REG_SCRATCH_EN
    logic [31:0]          scratch_q, scratch_d;
`endif

    logic [31:0]          offset;
    logic                 mapped;
    logic [31:0]          rd_val;
    logic                 acc_err;
    logic                 access;
    logic                 wr_ok;
    logic [31:0]          wmask;
    logic [NUM_IRQ-1:0]   sts_set;
    logic [NUM_IRQ-1:0]   sts_clr;
    logic                 cnt_clr;

    // Address decode and read mux on the current register values
    always_comb begin
        offset = reg_req_i.addr - BASE_ADDR;
        mapped = 1'b1;
        rd_val = '0;
        case (offset)
            OFS_CTRL:     rd_val = ctrl_q;
            OFS_LOW_WM:   rd_val = low_wm_q;
            OFS_CMPCT_TH: rd_val = cmpct_th_q;
            OFS_STATUS:   rd_val = {16'h0, freepage_count_i};
            OFS_INT_STS:  rd_val = {28'h0, int_sts_q};
            OFS_INT_EN:   rd_val = {28'h0, int_en_q};
            OFS_CMP_CNT:  rd_val = cmp_cnt_q;
`ifdef HAWK_REG_SCRATCH_EN
            OFS_SCRATCH:  rd_val = scratch_q;
`endif
            default:      mapped = 1'b0;
        endcase
        acc_err = (reg_req_i.addr[1:0] != 2'b00) || !mapped
                  || (reg_req_i.write && (offset == OFS_STATUS));
        access  = (state_q == IDLE) && reg_req_i.valid;
        wr_ok   = access && reg_req_i.write && !acc_err;
        wmask   = {{8{reg_req_i.wstrb[3]}}, {8{reg_req_i.wstrb[2]}},
                   {8{reg_req_i.wstrb[1]}}, {8{reg_req_i.wstrb[0]}}};
    end

    // Handshake FSM and registered response next-state
    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    state_d = RESP;
                    error_d = acc_err;
                    if (!reg_req_i.write && !acc_err) begin
                        rdata_d = rd_val;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == RESP);
    end

    // Register file, interrupt status and counter next-state
    always_comb begin
        ctrl_d     = ctrl_q;
        low_wm_d   = low_wm_q;
        cmpct_th_d = cmpct_th_q;
        int_en_d   = int_en_q;
        cmp_cnt_d  = cmp_cnt_q;
`ifdef HAWK_REG_SCRATCH_EN
        scratch_d  = scratch_q;
`endif
        sts_clr    = '0;
        cnt_clr    = 1'b0;
        if (wr_ok) begin
            case (offset)
                OFS_CTRL:     ctrl_d     = (ctrl_q & ~wmask) | (reg_req_i.wdata & wmask);
                OFS_LOW_WM:   low_wm_d   = (low_wm_q & ~wmask) | (reg_req_i.wdata & wmask);
                OFS_CMPCT_TH: cmpct_th_d = (cmpct_th_q & ~wmask) | (reg_req_i.wdata & wmask);
                OFS_INT_STS:  if (reg_req_i.wstrb[0]) sts_clr = reg_req_i.wdata[3:0];
                OFS_INT_EN:   if (reg_req_i.wstrb[0]) int_en_d = reg_req_i.wdata[3:0];
                OFS_CMP_CNT:  cnt_clr = 1'b1;
`ifdef HAWK_REG_SCRATCH_EN
                OFS_SCRATCH:  scratch_d  = (scratch_q & ~wmask) | (reg_req_i.wdata & wmask);
`endif
                default: ;
            endcase
        end
        // Watermark crossing is edge-detected so a sustained low count fires once
        below_d   = (freepage_count_i < low_wm_q[15:0]);
        sts_set   = {below_d && !below_q, illegal_access_i, decomp_done_i, cmpresn_done_i};
        int_sts_d = (int_sts_q & ~sts_clr) | sts_set;
        if (cnt_clr) begin
            cmp_cnt_d = cmpresn_done_i ? 32'd1 : 32'd0;
        end else if (cmpresn_done_i && (cmp_cnt_q != 32'hFFFF_FFFF)) begin
            cmp_cnt_d = cmp_cnt_q + 32'd1;
        end
        irq_d = |(int_sts_q & int_en_q);
    end

    // State, response and register flops with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            ctrl_q     <= '0;
            low_wm_q   <= 32'h0000_0100;
            cmpct_th_q <= 32'h0000_0040;
            int_sts_q  <= '0;
            int_en_q   <= '0;
            cmp_cnt_q  <= '0;
            below_q    <= 1'b0;
            irq_q      <= 1'b0;
`ifdef HAWK_REG_SCRATCH_EN
            scratch_q  <= 32'hDEAD_BEEF;
`endif
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            ctrl_q     <= ctrl_d;
            low_wm_q   <= low_wm_d;
            cmpct_th_q <= cmpct_th_d;
            int_sts_q  <= int_sts_d;
            int_en_q   <= int_en_d;
            cmp_cnt_q  <= cmp_cnt_d;
            below_q    <= below_d;
            irq_q      <= irq_d;
`ifdef HAWK_REG_SCRATCH_EN
            scratch_q  <= scratch_d;
`endif
        end
    end

    assign reg_resp_o.rdata   = rdata_q;
    assign reg_resp_o.error   = error_q;
    assign reg_resp_o.ready   = ready_q;
    assign hawk_regs_o.ctrl     = ctrl_q;
    assign hawk_regs_o.low_wm   = low_wm_q;
    assign hawk_regs_o.cmpct_th = cmpct_th_q;
    assign irq_o              = irq_q;

endmodule

// File: tb/tb_hawk_reg_slave.sv
// Self-checking bench for hawk_reg_slave: directed vector table, corner-case
// sequences and randomized accesses against an array-based register model.

module tb_hawk_reg_slave;
    import hawk_reg_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic                clk = 1'b0;
    logic                rst_n;
    reg_intf_req_a32_d32 req;
    reg_intf_resp_d32    resp;
    hawk_regs_intf       regs;
    logic [15:0]         fp;
    logic                cmp_p, dec_p, ill_p;
    logic                irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hawk_reg_slave #(.BASE_ADDR(BASE)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .reg_req_i        (req),
        .reg_resp_o       (resp),
        .hawk_regs_o      (regs),
        .freepage_count_i (fp),
        .cmpresn_done_i   (cmp_p),
        .decomp_done_i    (dec_p),
        .illegal_access_i (ill_p),
        .irq_o            (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One transaction; pulse = {illegal, decomp, cmpresn} driven in the sampling cycle
    task automatic access(input logic [31:0] off, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pulse,
                          output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        req.addr  = BASE + off;
        req.write = wr;
        req.wdata = wd;
        req.wstrb = st;
        req.valid = 1'b1;
        {ill_p, dec_p, cmp_p} = pulse;
        n = 0;
        do begin
            @(posedge clk); #1;
            {ill_p, dec_p, cmp_p} = 3'b000;
            n++;
        end while (!resp.ready && n < 4);
        check("ready_latency", 32'(n), 32'd1);
        rd = resp.rdata;
        er = resp.error;
        req.valid = 1'b0;
        @(posedge clk); #1;
        check("ready_single_cycle", {31'b0, resp.ready}, 32'd0);
    endtask

    task automatic pulse_src(input logic [2:0] pulse);
        @(negedge clk);
        {ill_p, dec_p, cmp_p} = pulse;
        @(posedge clk); #1;
        {ill_p, dec_p, cmp_p} = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] off;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl[16];

    // Register model: index = word offset, 3 = STATUS (computed), 4 = INT_STS, 6 = CMP_CNT
    logic [31:0] mdl[8];

    function automatic logic [31:0] bytemask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] off, wd, exp_rd, m;
        logic        wr, exp_er, in_map;
        logic [3:0]  st;
        int          idx;
        logic [31:0] win;

`ifdef HAWK_REG_SCRATCH_EN
        win = 32'h20;
`else
        win = 32'h1C;
`endif

        req   = '0;
        rst_n = 1'b0;
        fp    = 16'h1000;
        {ill_p, dec_p, cmp_p} = 3'b000;
        do_reset();

        // Reset state
        check("rst_ready", {31'b0, resp.ready}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_ctrl", regs.ctrl, 32'h0);
        check("rst_low_wm", regs.low_wm, 32'h100);
        check("rst_cmpct_th", regs.cmpct_th, 32'h40);

        // Directed vector table
        tbl[0]  = '{32'h04, 1'b0, 32'h0,          4'h0,    32'h0000_0100, 1'b0};
        tbl[1]  = '{32'h00, 1'b0, 32'h0,          4'h0,    32'h0,         1'b0};
        tbl[2]  = '{32'h08, 1'b0, 32'h0,          4'h0,    32'h0000_0040, 1'b0};
        tbl[3]  = '{32'h08, 1'b1, 32'h1234_5678,  4'b0011, 32'h0,         1'b0};
        tbl[4]  = '{32'h08, 1'b0, 32'h0,          4'h0,    32'h0000_5678, 1'b0};
        tbl[5]  = '{32'h0C, 1'b0, 32'h0,          4'h0,    32'h0000_1000, 1'b0};
        tbl[6]  = '{32'h02, 1'b0, 32'h0,          4'h0,    32'h0,         1'b1};
        tbl[7]  = '{32'h20, 1'b0, 32'h0,          4'h0,    32'h0,         1'b1};
        tbl[8]  = '{32'h0C, 1'b1, 32'hFFFF_FFFF,  4'hF,    32'h0,         1'b1};
`ifdef HAWK_REG_SCRATCH_EN
        tbl[9]  = '{32'h1C, 1'b0, 32'h0,          4'h0,    32'hDEAD_BEEF, 1'b0};
`else
        tbl[9]  = '{32'h1C, 1'b0, 32'h0,          4'h0,    32'h0,         1'b1};
`endif
        tbl[10] = '{32'h00, 1'b1, 32'hAABB_CCDD,  4'b1010, 32'h0,         1'b0};
        tbl[11] = '{32'h00, 1'b0, 32'h0,          4'h0,    32'hAA00_CC00, 1'b0};
        tbl[12] = '{32'h02, 1'b1, 32'hFFFF_FFFF,  4'hF,    32'h0,         1'b1};
        tbl[13] = '{32'h00, 1'b0, 32'h0,          4'h0,    32'hAA00_CC00, 1'b0};
        tbl[14] = '{32'h18, 1'b0, 32'h0,          4'h0,    32'h0,         1'b0};
        tbl[15] = '{32'h14, 1'b0, 32'h0,          4'h0,    32'h0,         1'b0};
        for (int i = 0; i < 16; i++) begin
            access(tbl[i].off, tbl[i].wr, tbl[i].wd, tbl[i].st, 3'b000, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_error", i), {31'b0, er}, {31'b0, tbl[i].exp_er});
            if (i == 4) check("cmpct_th_port", regs.cmpct_th, 32'h0000_5678);
            if (i == 8) check("status_write_noeffect", regs.ctrl, 32'h0);
        end
        check("misaligned_write_noeffect", regs.ctrl, 32'hAA00_CC00);

        // Compression-done interrupt, counter and W1C clear
        access(32'h14, 1'b1, 32'h1, 4'h1, 3'b000, rd, er);
        pulse_src(3'b001);
        check("irq_lag", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_set", {31'b0, irq}, 32'd1);
        access(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
        check("int_sts_bit0", rd, 32'h1);
        access(32'h18, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
        check("cmp_cnt_one", rd, 32'h1);
        access(32'h10, 1'b1, 32'h1, 4'h1, 3'b000, rd, er);
        check("irq_cleared", {31'b0, irq}, 32'd0);

        // Set wins over same-cycle W1C clear
        pulse_src(3'b010);
        access(32'h10, 1'b1, 32'h2, 4'h1, 3'b010, rd, er);
        access(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
        check("set_wins_clear", rd, 32'h2);
        access(32'h10, 1'b1, 32'h2, 4'h1, 3'b000, rd, er);
        access(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
        check("w1c_bit1", rd, 32'h0);

        // Counter clear coinciding with increment
        access(32'h18, 1'b1, 32'h0, 4'h0, 3'b001, rd, er);
        access(32'h18, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
        check("cnt_clear_and_inc", rd, 32'h1);

        // Watermark crossing fires once
        access(32'h10, 1'b1, 32'hF, 4'h1, 3'b000, rd, er);
        access(32'h04, 1'b1, 32'd10, 4'hF, 3'b000, rd, er);
        @(negedge clk); fp = 16'd12;
        @(negedge clk); fp = 16'd9;
        @(negedge clk); fp = 16'd8;
        @(negedge clk);
        access(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
        check("wm_edge_once", rd, 32'h8);
        access(32'h10, 1'b1, 32'h8, 4'h1, 3'b000, rd, er);
        @(negedge clk); fp = 16'd7;
        @(negedge clk);
        access(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
        check("wm_no_retrigger", rd, 32'h0);

        // Reset asserted while in RESP
        fp = 16'hFFFF;
        @(negedge clk);
        req.addr = BASE + 32'h04; req.write = 1'b0; req.valid = 1'b1;
        @(posedge clk); #1;
        check("resp_before_reset", {31'b0, resp.ready}, 32'd1);
        rst_n = 1'b0; req.valid = 1'b0;
        @(posedge clk); #1;
        check("ready_drop_on_reset", {31'b0, resp.ready}, 32'd0);
        check("rdata_drop_on_reset", resp.rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        check("low_wm_after_reset", regs.low_wm, 32'h100);

        // Randomized accesses against the register model
        mdl[0] = 32'h0; mdl[1] = 32'h100; mdl[2] = 32'h40; mdl[3] = 32'h0;
        mdl[4] = 32'h0; mdl[5] = 32'h0;   mdl[6] = 32'h0;  mdl[7] = 32'hDEAD_BEEF;
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                pulse_src(3'b001);
                @(posedge clk); #1;
                if (mdl[6] != 32'hFFFF_FFFF) mdl[6] = mdl[6] + 32'd1;
                mdl[4] = mdl[4] | 32'h1;
            end else begin
                off = 32'($urandom_range(0, 9)) * 32'd4;
                if ($urandom_range(0, 7) == 0) off = off + 32'($urandom_range(1, 3));
                wr = 1'($urandom_range(0, 1));
                wd = $urandom;
                st = 4'($urandom_range(0, 15));
                idx = int'(off >> 2);
                in_map = (off[1:0] == 2'b00) && (off < win);
                exp_er = !in_map || (wr && off == 32'h0C);
                exp_rd = 32'h0;
                if (!exp_er && !wr) exp_rd = (idx == 3) ? {16'h0, fp} : mdl[idx];
                access(off, wr, wd, st, 3'b000, rd, er);
                check($sformatf("rand%0d_rdata_off%0h", it, off), rd, exp_rd);
                check($sformatf("rand%0d_error_off%0h", it, off), {31'b0, er}, {31'b0, exp_er});
                if (!exp_er && wr) begin
                    m = bytemask(st);
                    case (idx)
                        4: if (st[0]) mdl[4] = mdl[4] & ~{28'h0, wd[3:0]};
                        5: if (st[0]) mdl[5] = {28'h0, wd[3:0]};
                        6: mdl[6] = 32'h0;
                        default: mdl[idx] = (mdl[idx] & ~m) | (wd & m);
                    endcase
                end
            end
            check($sformatf("rand%0d_irq", it), {31'b0, irq}, {31'b0, |(mdl[4] & mdl[5])});
        end
        check("rand_ctrl_port", regs.ctrl, mdl[0]);
        check("rand_low_wm_port", regs.low_wm, mdl[1]);
        check("rand_cmpct_th_port", regs.cmpct_th, mdl[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hawk_reg_slave.md
HAWK_REG_SLAVE -- requirements
Module: hawk_reg_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base address of the register window.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset; one clock, synchronous, active-low.
REQ-004 SHALL have port reg_req_i, input, reg_intf_req_a32_d32: fields addr, write, wdata, wstrb, valid.
REQ-005 SHALL have port reg_resp_o, output, reg_intf_resp_d32: fields rdata, error, ready.
REQ-006 SHALL have port hawk_regs_o, output, hawk_regs_intf: fields ctrl, low_wm, cmpct_th driven to the HACD core.
REQ-007 SHALL have port freepage_count_i, input, 16 bits: live free-page count.
REQ-008 SHALL have port cmpresn_done_i, input, 1 bit: compression-done pulse.
REQ-009 SHALL have port decomp_done_i, input, 1 bit: decompression-done pulse.
REQ-010 SHALL have port illegal_access_i, input, 1 bit: illegal Hawk-table access pulse.
REQ-011 SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-012 SHALL decode word offsets from BASE_ADDR as follows:
- 0x00 CTRL: RW.
- 0x04 LOW_WM: RW.
- 0x08 CMPCT_TH: RW.
- 0x0C STATUS: RO, value {16'h0, freepage_count_i}.
- 0x10 INT_STS: W1C, bits [3:0].
- 0x14 INT_EN: RW, bits [3:0].
- 0x18 CMP_CNT: read returns the count; any write clears it.
REQ-013 SHALL use a two-state FSM IDLE/RESP: IDLE with valid=1 performs the access and moves to RESP; RESP always returns to IDLE.
REQ-014 SHALL drive ready=1 only in RESP, giving exactly one ready cycle per transaction, one cycle after valid is sampled.
REQ-015 SHALL ignore valid sampled in RESP, so the initiator holds valid until it sees ready; maximum throughput is one access per 2 cycles.
REQ-016 SHALL register rdata and error in the IDLE->RESP transition and hold them 0 outside RESP.
REQ-017 SHALL give read data for the sampled address; write responses return rdata=0.
REQ-018 SHALL apply wstrb per byte on RW writes; unstrobed bytes are unchanged.
REQ-019 SHALL flag error=1 for any of: addr[1:0]!=0, offset unmapped, or a write to STATUS; the access has no side effects and rdata=0.
REQ-020 SHALL set INT_STS bits from these sources: bit0 cmpresn_done_i, bit1 decomp_done_i, bit2 illegal_access_i, bit3 rising edge of (freepage_count_i < LOW_WM[15:0]).
REQ-021 SHALL clear INT_STS bits written as 1 within strobed bytes; a set event in the same cycle wins over the clear.
REQ-022 SHALL increment CMP_CNT on each cmpresn_done_i cycle, saturating at 32'hFFFF_FFFF.
REQ-023 SHALL, when a CMP_CNT clear-write and an increment occur in the same cycle, produce CMP_CNT=1.
REQ-024 SHALL register irq_o = |(INT_STS & INT_EN[3:0]), one cycle after the status update.
REQ-025 SHALL drive hawk_regs_o combinationally from the CTRL, LOW_WM and CMPCT_TH flops.

Reset
REQ-026 SHALL, on rst_ni=0 at a clock edge, set: FSM to IDLE, reg_resp_o all 0, CTRL 0, LOW_WM 32'h100, CMPCT_TH 32'h40, INT_STS 0, INT_EN 0, CMP_CNT 0, irq_o 0, and the watermark edge-detect history bit 0.
REQ-027 SHALL drop ready to 0 on the next cycle when reset is asserted in RESP; the aborted access needs no response.

Configuration
REQ-028 SHALL, with HAWK_REG_SCRATCH_EN defined, map offset 0x1C SCRATCH: RW, reset 32'hDEAD_BEEF, wstrb honoured.
REQ-029 SHALL, without HAWK_REG_SCRATCH_EN, treat offset 0x1C as unmapped (error=1, rdata=0).

Verification
REQ-030 SHALL cover: reset, then read 0x04 -> ready exactly one cycle after valid, rdata=32'h100, error=0.
REQ-031 SHALL cover: write 0x08 with wdata=32'h1234_5678, wstrb=4'b0011 -> read returns 32'h0000_5678 and hawk_regs_o.cmpct_th matches.
REQ-032 SHALL cover: INT_EN=4'h1, pulse cmpresn_done_i -> INT_STS=1 and irq_o=1 one cycle later, CMP_CNT=1; W1C write 1 to 0x10 -> irq_o=0.
REQ-033 SHALL cover: W1C clear of bit1 in the same cycle as a decomp_done_i pulse -> bit1 stays 1.
REQ-034 SHALL cover: error accesses to addr 0x02, 0x20 and a write to 0x0C -> error=1, rdata=0, no register change; 0x1C error status per HAWK_REG_SCRATCH_EN.
REQ-035 SHALL cover: LOW_WM=10, freepage_count_i stepping 12->9->8 -> INT_STS bit3 set once only.
